fetch_unit: RTL

// - Instruction-fetch front end feeding the decode/execute datapath inside core; drives the ibus towards the I-cache.
// - Owns the fetch PC and keeps at most one ibus transaction in flight.
// - Buffers returned instructions in a small FIFO so decode stalls never break the bus handshake.
// - Accepts redirects (branch/jump) from downstream and discards any stale in-flight response.

---
 rtl/fetch_unit.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: instruction-fetch front end. Owns the fetch PC, keeps at most
// one ibus transaction in flight, buffers returned instructions in a small
// FIFO and handles downstream redirects by dropping stale responses.
// Optional feature: define FETCH_PERF_EN to add the perf_stall_cnt output,
// which counts cycles in which no instruction is available to decode.
module fetch_unit #(
  parameter logic [63:0] RESET_PC   = 64'h0000_0000_8000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        ireq_valid,
  output logic [63:0] ireq_addr,
  input  logic        iresp_addr_ok,
  input  logic        iresp_data_ok,
  input  logic [31:0] iresp_data,
  input  logic        redirect_valid,
  input  logic [63:0] redirect_pc,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [63:0] out_pc,
  output logic [31:0] out_instr
`ifdef FETCH_PERF_EN
  ,
  output logic [31:0] perf_stall_cnt
`endif
);

  localparam int               PTR_W     = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [PTR_W:0]   DEPTH_CNT = (PTR_W + 1)'(FIFO_DEPTH);
  localparam logic [PTR_W:0]   CNT_ONE   = (PTR_W + 1)'(1);
  localparam logic [PTR_W-1:0] PTR_ONE   = PTR_W'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [63:0]       pc_q, pc_d;
  logic [63:0]       req_addr_q, req_addr_d;
  logic              drop_q, drop_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W:0]    count_q, count_d;
  logic [63:0]       fifo_pc_q    [FIFO_DEPTH];
  logic [63:0]       fifo_pc_d    [FIFO_DEPTH];
  logic [31:0]       fifo_instr_q [FIFO_DEPTH];
  logic [31:0]       fifo_instr_d [FIFO_DEPTH];

  logic              complete;
  logic              push;
  logic              pop;
  logic [63:0]       redirect_pc_aligned;

  // Instruction addresses are word aligned, so the low two bits are ignored.
  assign redirect_pc_aligned = redirect_pc & ~64'h3;

  assign ireq_valid = (state_q == ST_REQ);
  assign ireq_addr  = req_addr_q;
  assign out_valid  = (count_q != '0);
  assign out_pc     = out_valid ? fifo_pc_q[rd_ptr_q]    : 64'd0;
  assign out_instr  = out_valid ? fifo_instr_q[rd_ptr_q] : 32'd0;

  // A redirect flushes the buffer, so a same-cycle pop must not move pointers.
  assign pop = out_valid && out_ready && !redirect_valid;

  // Bus FSM: IDLE decides whether a slot is free, REQ holds the request until
  // the cache accepts it, WAIT sits out the data latency.
  always_comb begin
    state_d  = state_q;
    complete = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (redirect_valid || (count_q < DEPTH_CNT)) begin
          state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (iresp_addr_ok) begin
          if (iresp_data_ok) begin
            complete = 1'b1;
            state_d  = ST_IDLE;
          end else begin
            state_d = ST_WAIT;
          end
        end
      end
      ST_WAIT: begin
        if (iresp_data_ok) begin
          complete = 1'b1;
          state_d  = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // PC, drop flag and request address; redirect wins over the increment and
  // the request address is only captured on issue so it stays stable in REQ.
  always_comb begin
    pc_d       = pc_q;
    drop_d     = drop_q;
    req_addr_d = req_addr_q;
    push       = 1'b0;
    if (complete) begin
      drop_d = 1'b0;
      if (!drop_q && !redirect_valid) begin
        push = 1'b1;
        pc_d = pc_q + 64'd4;
      end
    end
    if (redirect_valid) begin
      pc_d = redirect_pc_aligned;
      if ((state_q != ST_IDLE) && !complete) begin
        drop_d = 1'b1;
      end
    end
    if ((state_q == ST_IDLE) && (state_d == ST_REQ)) begin
      req_addr_d = pc_d;
    end
  end

  // Instruction buffer bookkeeping; the issue rule keeps a push off a full FIFO.
  always_comb begin
    rd_ptr_d     = rd_ptr_q;
    wr_ptr_d     = wr_ptr_q;
    count_d      = count_q;
    fifo_pc_d    = fifo_pc_q;
    fifo_instr_d = fifo_instr_q;
    if (redirect_valid) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PTR_ONE;
      end
      if (push) begin
        fifo_pc_d[wr_ptr_q]    = req_addr_q;
        fifo_instr_d[wr_ptr_q] = iresp_data;
        wr_ptr_d               = wr_ptr_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_ONE;
        2'b01:   count_d = count_q - CNT_ONE;
        default: count_d = count_q;
      endcase
    end
  end

  // State registers with synchronous reset; a late data_ok after reset finds
  // the FSM in IDLE and is ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      req_addr_q   <= RESET_PC;
      drop_q       <= 1'b0;
      rd_ptr_q     <= '0;
      wr_ptr_q     <= '0;
      count_q      <= '0;
      fifo_pc_q    <= '{default: '0};
      fifo_instr_q <= '{default: '0};
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      req_addr_q   <= req_addr_d;
      drop_q       <= drop_d;
      rd_ptr_q     <= rd_ptr_d;
      wr_ptr_q     <= wr_ptr_d;
      count_q      <= count_d;
      fifo_pc_q    <= fifo_pc_d;
      fifo_instr_q <= fifo_instr_d;
    end
  end

`ifdef FETCH_PERF_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  // Count decode-starved cycles, saturating instead of wrapping.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (!out_valid && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_q <= '0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule
